// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer
// Debug reader for the miniRV register file. On request it snapshots every
// architectural register and streams the snapshot as a byte-wide valid/ready
// frame: HEADER, then each register MSB byte first, then an XOR checksum of
// the data bytes. It only ever reads the register file.
module reg_dump_streamer #(
    parameter int         NUM_REGS = 16,
    parameter logic [7:0] HEADER   = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dump_req,
    input  logic [32*NUM_REGS-1:0]  reg_vals_flat,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      snap_reg [NUM_REGS];
    logic [IDX_W-1:0] reg_idx_reg, reg_idx_next;
    logic [1:0]       byte_idx_reg, byte_idx_next;
    logic [7:0]       csum_reg, csum_next;
    logic             done_reg, done_next;
    logic             capture;
    logic [31:0]      cur_word;
    logic [7:0]       data_byte;

    // Byte currently due in the DATA phase: byte_idx 0 is the register's MSB.
    assign cur_word = snap_reg[reg_idx_reg];

    // Select the byte of the current snapshot word that is being presented.
    always_comb begin
        data_byte = 8'h00;
        case (byte_idx_reg)
            2'd0: data_byte = cur_word[31:24];
            2'd1: data_byte = cur_word[23:16];
            2'd2: data_byte = cur_word[15:8];
            default: data_byte = cur_word[7:0];
        endcase
    end

    // Snapshot registers: loaded all at once on the accepting edge, so later
    // register-file activity cannot leak into a frame in progress.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_snap
            // Capture register gi when a dump request is accepted in IDLE.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    snap_reg[gi] <= 32'h0;
                end else if (capture) begin
                    snap_reg[gi] <= reg_vals_flat[32*gi +: 32];
                end
            end
        end
    endgenerate

    // State, counters, checksum and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            reg_idx_reg  <= '0;
            byte_idx_reg <= 2'd0;
            csum_reg     <= 8'h00;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            reg_idx_reg  <= reg_idx_next;
            byte_idx_reg <= byte_idx_next;
            csum_reg     <= csum_next;
            done_reg     <= done_next;
        end
    end

    // Next-state and output decode. Outputs come straight from registered
    // state, so a reset clears them immediately and out_data holds while
    // the sink stalls.
    always_comb begin
        state_next    = state_reg;
        reg_idx_next  = reg_idx_reg;
        byte_idx_next = byte_idx_reg;
        csum_next     = csum_reg;
        done_next     = 1'b0;
        capture       = 1'b0;
        out_valid     = 1'b0;
        out_data      = 8'h00;

        case (state_reg)
            IDLE: begin
                if (dump_req) begin
                    capture       = 1'b1;
                    reg_idx_next  = '0;
                    byte_idx_next = 2'd0;
                    csum_next     = 8'h00;
                    state_next    = HDR;
                end
            end
            HDR: begin
                out_valid = 1'b1;
                out_data  = HEADER;
                if (out_ready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                out_valid = 1'b1;
                out_data  = data_byte;
                if (out_ready) begin
                    csum_next     = csum_reg ^ data_byte;
                    // Two-bit counter wraps 3 -> 0 on its own.
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        if (reg_idx_reg == LAST_IDX) begin
                            state_next = CSUM;
                        end else begin
                            reg_idx_next = reg_idx_reg + 1'b1;
                        end
                    end
                end
            end
            CSUM: begin
                out_valid = 1'b1;
                out_data  = csum_reg;
                if (out_ready) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Scoreboard bench for reg_dump_streamer: stimulus pushes the expected frame
// bytes, a negedge monitor pops and compares every byte the sink accepts.
module tb_reg_dump_streamer;

    localparam int NR = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              dump_req = 1'b0;
    logic [32*NR-1:0]  reg_vals = '0;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              busy;
    logic              done;

    int                n_vec = 0;
    int                n_fail = 0;
    int                xfer_cnt = 0;
    logic [7:0]        exp_q[$];
    logic              stall_pending = 1'b0;
    logic [7:0]        stall_data = 8'h00;
    int                hold_cnt = 0;
    logic              poked = 1'b0;

    reg_dump_streamer #(.NUM_REGS(NR), .HEADER(8'hA5)) dut (
        .clk           (clk),
        .rst           (rst),
        .dump_req      (dump_req),
        .reg_vals_flat (reg_vals),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Monitor: inputs change 1ns after posedge, so at negedge the values that
    // the next posedge will act on are stable.
    always @(negedge clk) begin
        if (rst) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending) begin
                n_vec++;
                if (!out_valid || out_data !== stall_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: got valid=%0b data=%02h expected valid=1 data=%02h",
                             out_valid, out_data, stall_data);
                end
            end
            if (!out_valid) begin
                n_vec++;
                if (out_data !== 8'h00 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_outputs: got data=%02h busy=%0b expected data=00 busy=0",
                             out_data, busy);
                end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_byte: got %02h expected no byte", out_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e || busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL byte%0d: got %02h busy=%0b expected %02h busy=1",
                                 xfer_cnt, out_data, busy, e);
                    end
                end
                xfer_cnt++;
            end
            stall_pending = out_valid && !out_ready;
            stall_data    = out_data;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Expected frame: A5, each register MSB first, then the given checksum.
    task automatic push_frame(input logic [32*NR-1:0] v, input logic [7:0] cs);
        exp_q.push_back(8'hA5);
        for (int i = 0; i < NR; i++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(v[32*i + 24 - 8*b +: 8]);
        exp_q.push_back(cs);
    endtask

    // Raise dump_req for one sampling edge; returns 1ns into cycle 1 after it.
    task automatic request();
        @(posedge clk); #1;
        dump_req = 1'b1;
        @(posedge clk); #1;
        dump_req = 1'b0;
    endtask

    // Per-cycle sink / stimulus behaviour while a frame runs.
    // mode 0: ready high; mode 1: backpressure; mode 2: snapshot/ignore poke.
    task automatic apply(input int mode);
        if (mode == 1) begin
            if (xfer_cnt == 10 && hold_cnt < 5) begin
                out_ready = 1'b0;
                hold_cnt++;
            end else begin
                out_ready = ($urandom_range(0, 2) != 0);
            end
        end else if (mode == 2) begin
            out_ready = 1'b1;
            if (xfer_cnt == 20 && !poked) begin
                reg_vals[63:32] = 32'h0;
                dump_req = 1'b1;
                poked = 1'b1;
            end else begin
                dump_req = 1'b0;
            end
        end else begin
            out_ready = 1'b1;
        end
    endtask

    // Wait (bounded) for done; cycle 1 is the cycle right after the req edge.
    task automatic wait_done(input string name, input int mode, input int exp_cyc);
        int cyc = 1;
        apply(mode);
        while (!done && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            apply(mode);
        end
        out_ready = 1'b1;
        dump_req  = 1'b0;
        n_vec++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_done_timeout: got no done expected done", name);
        end else if (exp_cyc > 0 && cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL %s_done_cycle: got %0d expected %0d", name, cyc, exp_cyc);
        end
    endtask

    // done must be a single-cycle pulse and the scoreboard must be drained.
    task automatic end_frame(input string name);
        @(posedge clk); #1;
        check({name, "_done_width"}, {31'd0, done}, 32'd0);
        check({name, "_queue_left"}, exp_q.size(), 32'd0);
    endtask

    logic [32*NR-1:0] dead_vals;
    logic [32*NR-1:0] pat_vals;

    initial begin
        dead_vals = '0;
        dead_vals[63:32] = 32'hDEADBEEF;
        pat_vals = '0;
        for (int i = 0; i < NR; i++) pat_vals[32*i +: 32] = 32'(i) * 32'h11111111;

        // T1: asynchronous reset asserted mid-cycle clears outputs at once.
        #2 rst = 1'b1;
        #1;
        check("t1_valid", {31'd0, out_valid}, 32'd0);
        check("t1_busy",  {31'd0, busy},      32'd0);
        check("t1_done",  {31'd0, done},      32'd0);
        check("t1_data",  {24'd0, out_data},  32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // T2: reg1 = DEADBEEF, checksum DE^AD^BE^EF = 22, done in cycle 67.
        reg_vals = dead_vals;
        xfer_cnt = 0;
        push_frame(dead_vals, 8'h22);
        request();
        check("t2_header_valid", {31'd0, out_valid}, 32'd1);
        check("t2_header_data",  {24'd0, out_data},  32'hA5);
        wait_done("t2", 0, 67);
        end_frame("t2");

        // T3: reg i = i*11111111, four equal bytes per register, checksum 00.
        // The second frame is requested in the done cycle and runs back-to-back.
        reg_vals = pat_vals;
        xfer_cnt = 0;
        push_frame(pat_vals, 8'h00);
        push_frame(pat_vals, 8'h00);
        request();
        wait_done("t3a", 0, 67);
        dump_req = 1'b1;
        @(posedge clk); #1;
        dump_req = 1'b0;
        wait_done("t3b", 0, 67);
        end_frame("t3");

        // T4: same stream under backpressure, 5-cycle stall at byte 10.
        xfer_cnt = 0;
        hold_cnt = 0;
        push_frame(pat_vals, 8'h00);
        request();
        wait_done("t4", 1, 0);
        end_frame("t4");
        check("t4_stall_seen", hold_cnt, 32'd5);

        // T5: reg1 cleared and dump_req pulsed mid-frame; one DEADBEEF frame only.
        reg_vals = dead_vals;
        xfer_cnt = 0;
        poked = 1'b0;
        push_frame(dead_vals, 8'h22);
        request();
        wait_done("t5", 2, 0);
        end_frame("t5");
        repeat (10) @(posedge clk);
        #1;
        check("t5_no_second_busy", {31'd0, busy}, 32'd0);
        check("t5_xfer_total", xfer_cnt, 32'd66);

        // T6: reset after 10 transfers, then a fresh frame starting at A5.
        reg_vals = dead_vals;
        xfer_cnt = 0;
        push_frame(dead_vals, 8'h22);
        request();
        for (int g = 0; g < 100 && xfer_cnt < 10; g++) begin
            @(posedge clk); #1;
        end
        check("t6_reached_10", xfer_cnt, 32'd10);
        #2 rst = 1'b1;
        #1;
        check("t6_valid", {31'd0, out_valid}, 32'd0);
        check("t6_busy",  {31'd0, busy},      32'd0);
        check("t6_data",  {24'd0, out_data},  32'd0);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("t6_valid_after", {31'd0, out_valid}, 32'd0);
        xfer_cnt = 0;
        push_frame(dead_vals, 8'h22);
        request();
        wait_done("t6", 0, 67);
        end_frame("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
